// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, a one-entry output buffer
// with valid/ack handshake, framing-error pulse and sticky overrun flag.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit (8E1)
// between the data bits and the stop bit.
module uart_rx #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ack,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int DW  = $clog2(DIV);

   localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
   localparam logic [DW-1:0] HALF_LAST = DW'(DIV / 2 - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic          rx_meta;
   logic          rx_s;
   logic          rx_d;
   logic          rx_fall;
   logic [2:0]    state;
   logic [DW-1:0] divcnt;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic          break_guard;
   logic          bit_done;
   logic          stop_sample;
   logic          parity_ok;
   logic          byte_good;
   logic          byte_bad;

`ifdef UART_RX_PARITY_EN
   logic          par_bit;
`endif

   // Two-flop synchronizer plus one delay stage for falling-edge detection.
   // NOTE: the synchronizer resets to 1 (idle line) so reset release never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep each flop sampling the previous-cycle value of its source.
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
      end
   end

   assign rx_fall  = rx_d & ~rx_s;
   assign bit_done = (divcnt == DIV_LAST);
   assign busy     = (state != IDLE);

`ifdef UART_RX_PARITY_EN
   assign parity_ok = ((^shreg) == par_bit);
`else
   assign parity_ok = 1'b1;
`endif

   assign stop_sample = (state == STOP) && bit_done;
   assign byte_good   = stop_sample && rx_s && parity_ok;
   assign byte_bad    = stop_sample && !(rx_s && parity_ok);

   // Frame FSM: start detection, bit timing, shift register and error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         divcnt      <= '0;
         bitcnt      <= '0;
         shreg       <= '0;
         break_guard <= 1'b0;
         frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit     <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               divcnt <= '0;
               if (break_guard) begin
                  // After a bad stop bit the line must go idle before a new start is trusted.
                  if (rx_s) break_guard <= 1'b0;
               end else if (rx_fall) begin
                  state <= START;
               end
            end
            START: begin
               if (divcnt == HALF_LAST) begin
                  divcnt <= '0;
                  if (rx_s) begin
                     state <= IDLE;
                  end else begin
                     state  <= DATA;
                     bitcnt <= '0;
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  divcnt <= '0;
                  shreg  <= {rx_s, shreg[7:1]};
                  if (bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bitcnt <= bitcnt + 1'b1;
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (bit_done) begin
                  divcnt  <= '0;
                  par_bit <= rx_s;
                  state   <= STOP;
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (bit_done) begin
                  divcnt <= '0;
                  state  <= IDLE;
                  if (byte_bad) begin
                     frame_err   <= 1'b1;
                     break_guard <= 1'b1;
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               divcnt <= '0;
            end
         endcase
      end
   end

   // Output buffer: load a good byte, clear on ack, flag overrun when full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (ack && valid) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
         end
         if (byte_good) begin
            if (!valid || ack) begin
               data  <= shreg;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at DIV=100.
// Build with UART_RX_PARITY_EN defined to exercise the 8E1 variant.
module tb_uart_rx;

   localparam int DIV = 100;

`ifdef UART_RX_PARITY_EN
   localparam int EXP_LAT = 1053;
`else
   localparam int EXP_LAT = 953;
`endif

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       ack;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_cmp;
   int n_fail;
   int cyc;
   int start_cyc;
   int rise_cyc;
   int rise_cnt;
   int fe_cnt;
   logic       valid_q;
   logic [7:0] cap [0:31];
   int base_rise;
   int base_fe;

   uart_rx #(.CLK_HZ(100_000_000), .BAUD(1_000_000)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .ack       (ack),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder: valid rising edges (with data) and frame_err cycles.
   always @(negedge clk) begin
      if (valid && !valid_q) begin
         if (rise_cnt < 32) cap[rise_cnt] = data;
         rise_cnt = rise_cnt + 1;
         rise_cyc = cyc;
      end
      valid_q = valid;
      if (frame_err) fe_cnt = fe_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Hold rx at v for n clocks; always returns 1 time unit after a rising edge.
   task automatic drive_bit(input logic v, input int n);
      rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      start_cyc = cyc;
      drive_bit(1'b0, DIV);
      for (int i = 0; i < 8; i++) drive_bit(d[i], DIV);
`ifdef UART_RX_PARITY_EN
      drive_bit(par, DIV);
`else
      if (par) begin end
`endif
      drive_bit(stop, DIV);
   endtask

   task automatic send_good(input logic [7:0] d);
      send_frame(d, ^d, 1'b1);
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(posedge clk);
      #1;
      ack = 1'b0;
   endtask

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      cyc      = 0;
      rise_cnt = 0;
      fe_cnt   = 0;
      valid_q  = 1'b0;
      rx       = 1'b1;
      ack      = 1'b0;
      rst_n    = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_data", {24'd0, data}, 32'h00);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      drive_bit(1'b1, 20);

      // 1. Single byte 0xA5, latency from start edge
      send_good(8'hA5);
      check("t1_valid", {31'd0, valid}, 32'd1);
      check("t1_data", {24'd0, data}, 32'hA5);
      check("t1_frame_err_cnt", fe_cnt, 0);
      check("t1_rises", rise_cnt, 1);
      n_cmp++;
      assert ((rise_cyc - start_cyc) >= EXP_LAT - 1 && (rise_cyc - start_cyc) <= EXP_LAT + 1) else begin
         n_fail++;
         $error("FAIL t1_latency: got %0d want %0d+/-1", rise_cyc - start_cyc, EXP_LAT);
      end
      do_ack();
      check("t1_ack_valid", {31'd0, valid}, 32'd0);

      // 2. Back-to-back 0x00 then 0xFF, acked after each
      base_rise = rise_cnt;
      send_good(8'h00);
      fork
         send_good(8'hFF);
         begin
            drive_bit(rx, 0);
            repeat (5) @(posedge clk);
            #1;
            do_ack();
         end
      join
      do_ack();
      check("t2_rises", rise_cnt - base_rise, 2);
      check("t2_first", {24'd0, cap[base_rise]}, 32'h00);
      check("t2_second", {24'd0, cap[base_rise + 1]}, 32'hFF);
      check("t2_overrun", {31'd0, overrun}, 32'd0);
      check("t2_valid_after_ack", {31'd0, valid}, 32'd0);

      // 3. False start: rx low for 30 clocks
      drive_bit(1'b1, 50);
      base_rise = rise_cnt;
      base_fe   = fe_cnt;
      drive_bit(1'b0, 20);
      check("t3_busy_mid", {31'd0, busy}, 32'd1);
      drive_bit(1'b0, 10);
      drive_bit(1'b1, 26);
      check("t3_busy_end", {31'd0, busy}, 32'd0);
      drive_bit(1'b1, 1000);
      check("t3_no_valid", rise_cnt - base_rise, 0);
      check("t3_no_frame_err", fe_cnt - base_fe, 0);

      // 4. Bad stop bit on 0x3C, line held low, then 0x11
      base_rise = rise_cnt;
      base_fe   = fe_cnt;
      send_frame(8'h3C, ^8'h3C, 1'b0);
      check("t4_frame_err_pulse", fe_cnt - base_fe, 1);
      check("t4_valid", {31'd0, valid}, 32'd0);
      drive_bit(1'b0, 2 * DIV);
      drive_bit(1'b1, DIV);
      send_good(8'h11);
      check("t4_rises", rise_cnt - base_rise, 1);
      check("t4_data", {24'd0, data}, 32'h11);
      check("t4_no_more_frame_err", fe_cnt - base_fe, 1);
      do_ack();

      // 5. Overrun: 0x12 unacked, then 0x34
      drive_bit(1'b1, 50);
      base_rise = rise_cnt;
      send_good(8'h12);
      send_good(8'h34);
      check("t5_data_kept", {24'd0, data}, 32'h12);
      check("t5_overrun", {31'd0, overrun}, 32'd1);
      check("t5_valid", {31'd0, valid}, 32'd1);
      check("t5_rises", rise_cnt - base_rise, 1);
      do_ack();
      check("t5_ack_valid", {31'd0, valid}, 32'd0);
      check("t5_ack_overrun", {31'd0, overrun}, 32'd0);

      // 6. Reset during bit 4 of 0x55, then 0x66
      drive_bit(1'b1, 50);
      base_rise = rise_cnt;
      drive_bit(1'b0, DIV);
      drive_bit(1'b1, DIV);
      drive_bit(1'b0, DIV);
      drive_bit(1'b1, DIV);
      drive_bit(1'b0, DIV);
      drive_bit(1'b1, DIV / 2);
      check("t6_busy_before_rst", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      drive_bit(1'b1, 5);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_data", {24'd0, data}, 32'h00);
      rst_n = 1'b1;
      drive_bit(1'b1, 3 * DIV);
      send_good(8'h66);
      drive_bit(1'b1, 20);
      check("t6_rises", rise_cnt - base_rise, 1);
      check("t6_data", {24'd0, data}, 32'h66);
      do_ack();

`ifdef UART_RX_PARITY_EN
      // Parity: 0x07 has three ones, so the even-parity bit must be 1
      drive_bit(1'b1, 50);
      base_rise = rise_cnt;
      base_fe   = fe_cnt;
      send_frame(8'h07, 1'b0, 1'b1);
      check("par_bad_frame_err", fe_cnt - base_fe, 1);
      check("par_bad_no_valid", rise_cnt - base_rise, 0);
      drive_bit(1'b1, 50);
      send_frame(8'h07, 1'b1, 1'b1);
      check("par_good_rises", rise_cnt - base_rise, 1);
      check("par_good_data", {24'd0, data}, 32'h07);
      check("par_good_frame_err", fe_cnt - base_fe, 1);
      do_ack();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
